// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: permutation tables, rotate helpers and
// the default per-round shift schedule.
package des_pkg;

  typedef logic [0:27] half_t;
  typedef logic [0:47] subkey_t;

  // Bit index [0:15] = round 1..16; 1 = rotate by one, 0 = rotate by two.
  localparam logic [0:15] SHIFT_SCHED_DEF = 16'b1100_0000_1000_0001;

  // 1-based bit positions, MSB-first, as in the DES standard.
  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic half_t rotl(input half_t x, input logic by1);
    return by1 ? {x[1:27], x[0]} : {x[2:27], x[0:1]};
  endfunction

  function automatic half_t rotr(input half_t x, input logic by1);
    return by1 ? {x[27], x[0:26]} : {x[26:27], x[0:25]};
  endfunction

  function automatic int sched_total(input logic [0:15] s);
    int sum;
    sum = 0;
    for (int i = 0; i < 16; i++) sum += s[i] ? 1 : 2;
    return sum;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational DES permuted-choice 2: selects 48 of the 56 C/D bits.
module des_pc2
  import des_pkg::*;
(
  input  logic [0:55] cd,
  output logic [0:47] k
);

  for (genvar g = 0; g < 48; g++) begin : g_pc2
    assign k[g] = cd[PC2_TBL[g] - 1];
  end

  // PC-2 discards these eight positions by definition of the permutation.
  logic dropped_unused;
  assign dropped_unused = ^{cd[8], cd[17], cd[21], cd[24],
                            cd[34], cd[37], cd[42], cd[53]};

endmodule

// File: rtl/des_key_sched_ctrl.sv
// Iterative DES round-key sequencer: one C/D register pair, one PC-2, subkeys
// streamed K1..K16 (encrypt) or K16..K1 (decrypt) over valid/ready.
module des_key_sched_ctrl
  import des_pkg::*;
#(
  parameter logic [0:15] SHIFT_SCHED = SHIFT_SCHED_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [0:63] key,
  output logic        ready,
  output logic [0:47] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round,
  output logic        done,
  input  logic        abort
);

  if (sched_total(SHIFT_SCHED) != 28) begin : g_bad_sched
    $error("SHIFT_SCHED total rotation must be 28");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic       dec_p0;
  half_t      c_p0, d_p0;
  logic [3:0] round_p0;

  // PC-1 is pure wiring; parity bits never reach the C/D registers.
  logic [0:55] pc1_cd;
  for (genvar g = 0; g < 56; g++) begin : g_pc1
    assign pc1_cd[g] = key[PC1_TBL[g] - 1];
  end

  logic parity_unused;
  assign parity_unused = ^{key[7], key[15], key[23], key[31],
                           key[39], key[47], key[55], key[63]};

  logic       hs;
  logic       last;
  logic [3:0] fwd_idx;
  logic [3:0] rev_idx;
  half_t      c_nxt, d_nxt;

  assign hs      = (state == RUN) && subkey_ready;
  assign last    = (round_p0 == 4'd15);
  assign fwd_idx = round_p0 + 4'd1;
  assign rev_idx = 4'd15 - round_p0;

  // Encrypt walks forward to the next round's C/D; decrypt undoes the shift
  // of the round just emitted, stepping from C16D16 back toward C1D1.
  always_comb begin
    c_nxt = c_p0;
    d_nxt = d_p0;
    if (dec_p0) begin
      c_nxt = rotr(c_p0, SHIFT_SCHED[rev_idx]);
      d_nxt = rotr(d_p0, SHIFT_SCHED[rev_idx]);
    end else begin
      c_nxt = rotl(c_p0, SHIFT_SCHED[fwd_idx]);
      d_nxt = rotl(d_p0, SHIFT_SCHED[fwd_idx]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state    <= IDLE;
      dec_p0   <= 1'b0;
      round_p0 <= 4'd0;
      c_p0     <= '0;
      d_p0     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            round_p0 <= 4'd0;
            dec_p0   <= decrypt;
            if (decrypt) begin
              c_p0 <= pc1_cd[0:27];
              d_p0 <= pc1_cd[28:55];
            end else begin
              c_p0 <= rotl(pc1_cd[0:27], SHIFT_SCHED[0]);
              d_p0 <= rotl(pc1_cd[28:55], SHIFT_SCHED[0]);
            end
          end
        end
        RUN: begin
          if (hs) begin
            if (last) begin
              state <= DONE;
            end else begin
              round_p0 <= fwd_idx;
              c_p0     <= c_nxt;
              d_p0     <= d_nxt;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  des_pc2 u_pc2 (
    .cd ({c_p0, d_p0}),
    .k  (subkey)
  );

  assign ready        = (state == IDLE);
  assign subkey_valid = (state == RUN);
  assign done         = (state == DONE);
  assign round        = round_p0;

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Self-checking bench for des_key_sched_ctrl against a standard-table DES
// key-schedule model using cumulative rotation amounts.
module tb_des_key_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, decrypt, subkey_ready, abort;
  logic [63:0] key;
  logic        ready, subkey_valid, done;
  logic [47:0] subkey;
  logic [3:0]  round;

  int nchecks = 0;
  int nerr    = 0;
  logic [47:0] obs_log [16];

  always #5 clk = ~clk;

  des_key_sched_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .decrypt      (decrypt),
    .key          (key),
    .ready        (ready),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round        (round),
    .done         (done),
    .abort        (abort)
  );

  localparam int PC1M [56] = '{
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
    19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
    14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2M [48] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SHM [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // Subkey Kn: rotate C0 and D0 by the cumulative shift through round n.
  function automatic logic [47:0] model_key(input logic [63:0] k, input int n);
    logic [55:0] cd, t;
    logic [27:0] c, d;
    logic [47:0] r;
    int s;
    for (int i = 0; i < 56; i++) cd[6'(55 - i)] = k[6'(64 - PC1M[i])];
    s = 0;
    for (int j = 0; j < n; j++) s += SHM[j];
    t = {28'b0, cd[55:28]};
    t = (t << s) | (t >> (28 - s));
    c = t[27:0];
    t = {28'b0, cd[27:0]};
    t = (t << s) | (t >> (28 - s));
    d = t[27:0];
    cd = {c, d};
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2M[i])];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nchecks++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_valid"}, 64'(subkey_valid), 64'd0);
    check({tag, "_ready"}, 64'(ready), 64'd1);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_round"}, 64'(round), 64'd0);
    check({tag, "_subkey"}, 64'(subkey), 64'd0);
  endtask

  // k drives the DUT, mk drives the model; cut>0 interrupts after cut handshakes.
  task automatic run_sched(input logic [63:0] k, input logic [63:0] mk, input bit dec,
                           input bit rnd, input int cut, input bit use_rst, input bit inj);
    logic [47:0] expk [16];
    int hs, cyc;
    bit sr;
    for (int i = 0; i < 16; i++) expk[i] = model_key(mk, dec ? 16 - i : i + 1);
    check("pre_ready", 64'(ready), 64'd1);
    key = k; decrypt = dec; start = 1'b1; subkey_ready = 1'b0;
    tick;
    start = 1'b0;
    check("lat_valid", 64'(subkey_valid), 64'd1);
    hs = 0; cyc = 0;
    while (hs < 16 && cyc < 400) begin
      if (cut != 0 && hs == cut) begin
        if (use_rst) rst = 1'b1; else abort = 1'b1;
        subkey_ready = 1'($urandom_range(0, 1));
        tick;
        rst = 1'b0; abort = 1'b0;
        check_idle_reset(use_rst ? "rst_mid" : "abort_mid");
        return;
      end
      sr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      subkey_ready = sr;
      if (inj && hs == 3) begin
        start = 1'b1; key = ~k; decrypt = ~dec;
      end
      check("valid", 64'(subkey_valid), 64'd1);
      check("subkey", 64'(subkey), 64'(expk[hs]));
      check("round", 64'(round), 64'(hs));
      check("done_run", 64'(done), 64'd0);
      if (sr) obs_log[hs] = subkey;
      tick;
      start = 1'b0;
      if (sr) hs++;
      cyc++;
    end
    check("hs_count", 64'(hs), 64'd16);
    subkey_ready = 1'b0;
    check("done_pulse", 64'(done), 64'd1);
    check("done_valid", 64'(subkey_valid), 64'd0);
    check("done_ready", 64'(ready), 64'd0);
    tick;
    check("post_done", 64'(done), 64'd0);
    check("post_ready", 64'(ready), 64'd1);
  endtask

  localparam logic [63:0] KAT = 64'h133457799BBCDFF1;

  initial begin
    logic [63:0] rk;
    rst = 1'b1; start = 1'b0; decrypt = 1'b0; subkey_ready = 1'b0;
    abort = 1'b0; key = '0;
    tick;
    tick;
    check_idle_reset("reset");
    rst = 1'b0;
    tick;
    check_idle_reset("after_reset");

    run_sched(KAT, KAT, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("enc_k1", 64'(obs_log[0]), 64'h1B02EFFC7072);
    check("enc_k2", 64'(obs_log[1]), 64'h79AED9DBC9E5);
    check("enc_k16", 64'(obs_log[15]), 64'hCB3D8B0E17F5);

    run_sched(KAT, KAT, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    check("dec_first", 64'(obs_log[0]), 64'hCB3D8B0E17F5);
    check("dec_15th", 64'(obs_log[14]), 64'h79AED9DBC9E5);
    check("dec_16th", 64'(obs_log[15]), 64'h1B02EFFC7072);

    run_sched(KAT, KAT, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    run_sched(KAT, KAT, 1'b1, 1'b1, 0, 1'b0, 1'b0);

    run_sched(KAT, KAT, 1'b0, 1'b0, 5, 1'b0, 1'b0);
    run_sched(64'd0, 64'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("zero_k1", 64'(obs_log[0]), 64'd0);

    run_sched(KAT, KAT, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    run_sched(KAT, KAT, 1'b1, 1'b1, 7, 1'b1, 1'b0);

    // Flip only the parity bit of every byte: schedule must be unchanged.
    run_sched(KAT ^ 64'h0101010101010101, KAT, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    run_sched(KAT ^ 64'h0101010101010101, KAT, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("parity_k1", 64'(obs_log[0]), 64'h1B02EFFC7072);

    for (int n = 0; n < 4; n++) begin
      rk = {$urandom, $urandom};
      run_sched(rk, rk, 1'($urandom_range(0, 1)), 1'b1, 0, 1'b0, 1'($urandom_range(0, 1)));
    end

    key = 64'hFFFF_FFFF_FFFF_FFFF; start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    check_idle_reset("start_abort");
    tick;
    check("start_abort_stay", 64'(subkey_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
